// File: rtl/frame_draw_sequencer.sv
// ============================================================================
// frame_draw_sequencer
//   Schedules full-screen redraws for the 160x120 frame drawer from game state.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module frame_draw_sequencer #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int TIMER_W        = 15
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic [2:0] iState,
    input  logic       iDrawDone,
    output logic [2:0] oFrameSel,
    output logic       oStart,
    output logic       oDrawEnable,
    output logic       oFrameDone,
    output logic       oBusy,
    output logic       oTimeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_DRAW   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]         FRAME_NONE   = 3'd7;

    state_t             state;
    state_t             state_next;
    logic [2:0]         req_frame;
    logic [2:0]         req_frame_next;
    logic [2:0]         pend_frame;
    logic [2:0]         pend_frame_next;
    logic [2:0]         cur_frame;
    logic [2:0]         cur_frame_next;
    logic               pend;
    logic               pend_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               timeout_flag;
    logic               timeout_next;
    logic               new_req;
    logic               in_flight;
    logic               expired;

    always_comb begin
        new_req   = (iState != FRAME_NONE) && (iState != req_frame);
        in_flight = (state == ST_LAUNCH) || (state == ST_DRAW);
        expired   = (state == ST_DRAW) && !iDrawDone && (timer == '0);
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state        <= ST_IDLE;
            req_frame    <= FRAME_NONE;
            pend         <= 1'b0;
            pend_frame   <= 3'd0;
            cur_frame    <= 3'd0;
            timer        <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state        <= state_next;
            req_frame    <= req_frame_next;
            pend         <= pend_next;
            pend_frame   <= pend_frame_next;
            cur_frame    <= cur_frame_next;
            timer        <= timer_next;
            timeout_flag <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state;
        req_frame_next  = req_frame;
        pend_next       = pend;
        pend_frame_next = pend_frame;
        cur_frame_next  = cur_frame;
        timer_next      = timer;
        timeout_next    = timeout_flag;

        // cur_frame is latched on entry to LAUNCH so oFrameSel is already valid with oStart.
        case (state)
            ST_IDLE: begin
                if (pend) begin
                    state_next     = ST_LAUNCH;
                    cur_frame_next = pend_frame;
                end
            end
            ST_LAUNCH: begin
                pend_next  = 1'b0;
                timer_next = TIMER_RELOAD;
                state_next = ST_DRAW;
            end
            ST_DRAW: begin
                if (iDrawDone) begin
                    state_next = ST_DONE;
                end else if (timer == '0) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    timer_next = timer - TIMER_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A fresh request overrides LAUNCH's clear; one matching the frame in flight cancels.
        if (new_req) begin
            req_frame_next = iState;
            if (in_flight && (iState == cur_frame)) begin
                pend_next = 1'b0;
            end else begin
                pend_next       = 1'b1;
                pend_frame_next = iState;
            end
        end

        if (expired && !pend_next) begin
            pend_next       = 1'b1;
            pend_frame_next = cur_frame;
        end
    end

    always_comb begin
        oFrameSel   = cur_frame;
        oStart      = (state == ST_LAUNCH);
        oDrawEnable = (state == ST_DRAW);
        oFrameDone  = (state == ST_DONE);
        oBusy       = (state != ST_IDLE) || pend;
        oTimeout    = timeout_flag;
    end

endmodule

`default_nettype wire
